// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the word-organised data memory.
// Handles byte/half/word loads and stores with alignment and range checks,
// sign/zero extension on loads and read-modify-write for sub-word stores.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, and the requester keeps its request stable
// until taken. Completion is a single-cycle resp_valid pulse with resp_erro
// and resp_data valid in that same cycle.
module load_store_unit #(
   parameter int MEM_WORDS = 256
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_erro,
   output logic [31:0] resp_data,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] endereco,
   output logic [31:0] write_data,
   input  logic [31:0] read_data,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LEITURA = 2'd1,
      ESCRITA = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

   state_t      state_q;
   logic        ready_q;
   logic        store_q;
   logic [2:0]  op_q;
   logic [1:0]  lane_q;
   logic [15:0] wdata_q;
   logic        resp_valid_q;
   logic        resp_erro_q;
   logic [31:0] resp_data_q;
   logic        mem_read_q;
   logic        mem_write_q;
   logic [31:0] endereco_q;
   logic [31:0] write_data_q;

   logic        req_err_d;
   logic        needs_read_d;
   logic [31:0] load_ext_d;
   logic [31:0] merged_d;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Validate the incoming request: illegal op, misalignment or out of range.
   always_comb begin
      req_err_d = 1'b0;
      if (req_op == 3'b011 || req_op[2:1] == 2'b11 || (req_op[2] && req_store))
         req_err_d = 1'b1;
      if (req_op[1:0] == 2'b01 && req_addr[0] != 1'b0)
         req_err_d = 1'b1;
      if (req_op[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
         req_err_d = 1'b1;
      if ({1'b0, req_addr} >= ADDR_LIMIT)
         req_err_d = 1'b1;
      // Everything but a full-word store has to read the memory first.
      needs_read_d = !(req_store && req_op[1:0] == 2'b10);
   end

   // Lane extraction with extension for loads, lane merge for sub-word stores.
   always_comb begin
      byte_sel   = read_data[{lane_q, 3'b000} +: 8];
      half_sel   = read_data[{lane_q[1], 4'b0000} +: 16];
      load_ext_d = read_data;
      case (op_q)
         3'b000:  load_ext_d = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_ext_d = {24'h000000, byte_sel};
         3'b001:  load_ext_d = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_ext_d = {16'h0000, half_sel};
         default: load_ext_d = read_data;
      endcase
      merged_d = read_data;
      if (op_q[1:0] == 2'b00) begin
         merged_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged_d[{lane_q[1], 4'b0000} +: 16] = wdata_q;
      end
   end

   // Control FSM; every memory/response output is a register set on entry to its state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         ready_q      <= 1'b1;
         store_q      <= 1'b0;
         op_q         <= 3'b000;
         lane_q       <= 2'b00;
         wdata_q      <= 16'h0000;
         resp_valid_q <= 1'b0;
         resp_erro_q  <= 1'b0;
         resp_data_q  <= 32'h0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         endereco_q   <= 32'h0;
         write_data_q <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  ready_q <= 1'b0;
                  store_q <= req_store;
                  op_q    <= req_op;
                  lane_q  <= req_addr[1:0];
                  wdata_q <= req_wdata[15:0];
                  if (req_err_d) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_erro_q  <= 1'b1;
                     resp_data_q  <= 32'h0;
                  end else if (needs_read_d) begin
                     state_q    <= LEITURA;
                     mem_read_q <= 1'b1;
                     endereco_q <= {req_addr[31:2], 2'b00};
                  end else begin
                     state_q      <= ESCRITA;
                     mem_write_q  <= 1'b1;
                     endereco_q   <= {req_addr[31:2], 2'b00};
                     write_data_q <= req_wdata;
                  end
               end
            end
            LEITURA: begin
               mem_read_q <= 1'b0;
               if (store_q) begin
                  state_q      <= ESCRITA;
                  mem_write_q  <= 1'b1;
                  write_data_q <= merged_d;
               end else begin
                  state_q      <= RESP;
                  endereco_q   <= 32'h0;
                  resp_valid_q <= 1'b1;
                  resp_erro_q  <= 1'b0;
                  resp_data_q  <= load_ext_d;
               end
            end
            ESCRITA: begin
               state_q      <= RESP;
               mem_write_q  <= 1'b0;
               write_data_q <= 32'h0;
               endereco_q   <= 32'h0;
               resp_valid_q <= 1'b1;
               resp_erro_q  <= 1'b0;
               resp_data_q  <= 32'h0;
            end
            default: begin
               state_q      <= IDLE;
               ready_q      <= 1'b1;
               resp_valid_q <= 1'b0;
               resp_erro_q  <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready   = ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_erro   = resp_erro_q;
   assign resp_data   = resp_data_q;
   assign MemRead     = mem_read_q;
   assign MemWrite    = mem_write_q;
   assign endereco    = endereco_q;
   assign write_data  = write_data_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic, checked
// cycle by cycle against a byte-lane arithmetic model and a shadow memory.
module tb_load_store_unit;
   localparam int MEM_WORDS = 256;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [2:0]  req_op = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_erro;
   logic [31:0] resp_data;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] endereco;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic [1:0]  dbg_state;

   load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_erro(resp_erro), .resp_data(resp_data),
      .MemRead(MemRead), .MemWrite(MemWrite), .endereco(endereco),
      .write_data(write_data), .read_data(read_data), .dbg_state_o(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   // ---------------- data memory the unit talks to ----------------
   logic [31:0] dmem [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];
   assign read_data = MemRead ? dmem[endereco[9:2]] : 32'hDEAD_BEEF;
   always @(posedge clock) if (MemWrite) dmem[endereco[9:2]] <= write_data;

   // ---------------- scoreboard ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_data = 32'h0;
   bit          b2b = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Reference model: byte-lane arithmetic on the shadow memory.
   task automatic model(input bit st, input bit [2:0] op, input bit [31:0] addr,
                        input bit [31:0] wd, output bit err, output bit [31:0] data,
                        output int lat, output int rd_k, output int wr_k,
                        output bit [31:0] wword);
      int size;
      int sh;
      longint unsigned mask, old, v;
      size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
      err = (op == 3) || (op >= 6) || (st && op >= 4) || (addr % size != 0)
            || (addr >= MEM_WORDS * 4);
      data = 0; wword = 0; rd_k = 0; wr_k = 0; lat = 1;
      if (err) return;
      sh   = 8 * int'(addr % 4);
      mask = (64'd1 << (8 * size)) - 1;
      old  = longint'(ref_mem[addr / 4]);
      if (!st) begin
         v = (old >> sh) & mask;
         if (op < 4 && ((v >> (8 * size - 1)) & 1) == 1) v = v | ~mask;
         data = v[31:0];
         rd_k = 1; lat = 2;
      end else if (size == 4) begin
         wword = wd; wr_k = 1; lat = 2;
         ref_mem[addr / 4] = wd;
      end else begin
         v = (old & ~(mask << sh)) | ((longint'(wd) & mask) << sh);
         wword = v[31:0]; rd_k = 1; wr_k = 2; lat = 3;
         ref_mem[addr / 4] = wword;
      end
   endtask

   // ---------------- driver ----------------
   task automatic do_req(input bit st, input bit [2:0] op, input bit [31:0] addr,
                         input bit [31:0] wd, input bit hold);
      bit err;
      bit [31:0] data, wword, aligned, exp;
      int lat, rd_k, wr_k, waits;
      model(st, op, addr, wd, err, data, lat, rd_k, wr_k, wword);
      exp_q.push_back(data);
      aligned = {addr[31:2], 2'b00};
      req_store = st; req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      waits = 0;
      while (!req_ready && waits < 10) begin
         @(negedge clock);
         waits++;
      end
      if (!req_ready) begin
         check_eq("ready_timeout", req_ready, 1);
         req_valid = 1'b0;
         void'(exp_q.pop_front());
         return;
      end
      check_eq("accept_wait", waits, b2b ? 1 : 0);
      @(posedge clock);
      #1;
      if (!hold) req_valid = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clock);
         check_eq("MemRead", MemRead, k == rd_k);
         check_eq("MemWrite", MemWrite, k == wr_k);
         check_eq("endereco", endereco, (k == rd_k || k == wr_k) ? aligned : 32'h0);
         check_eq("write_data", write_data, (k == wr_k) ? wword : 32'h0);
         check_eq("resp_valid", resp_valid, k == lat);
         if (k == lat) begin
            exp = exp_q.pop_front();
            check_eq("resp_erro", resp_erro, err);
            check_eq("resp_data", resp_data, exp);
            last_data = exp;
         end
      end
      req_valid = 1'b0;
      b2b = 1'b1;
   endtask

   task automatic idle_check(input int n);
      repeat (n) begin
         @(negedge clock);
         check_eq("idle_ready", req_ready, 1);
         check_eq("idle_rd", MemRead, 0);
         check_eq("idle_wr", MemWrite, 0);
         check_eq("idle_resp", resp_valid, 0);
         check_eq("idle_hold", resp_data, last_data);
      end
      b2b = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, req_ready, 1);
      check_eq({tag, "_rv"}, resp_valid, 0);
      check_eq({tag, "_re"}, resp_erro, 0);
      check_eq({tag, "_rd"}, resp_data, 0);
      check_eq({tag, "_mr"}, MemRead, 0);
      check_eq({tag, "_mw"}, MemWrite, 0);
      check_eq({tag, "_addr"}, endereco, 0);
      check_eq({tag, "_wd"}, write_data, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit [31:0] a;
      for (int i = 0; i < MEM_WORDS; i++) begin
         dmem[i] = $urandom;
         ref_mem[i] = dmem[i];
      end
      dmem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
      dmem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;

      #1 reset_n = 1'b0;
      #2 check_reset_outputs("reset");
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      idle_check(1);

      // loads with sign/zero extension
      do_req(1'b0, 3'b000, 32'h11, 32'h0, 1'b0);
      check_eq("lb_const", resp_data, 32'hFFFFFFAA);
      do_req(1'b0, 3'b100, 32'h11, 32'h0, 1'b0);
      check_eq("lbu_const", resp_data, 32'h000000AA);
      // sub-word store with read-modify-write
      do_req(1'b1, 3'b001, 32'h22, 32'h0000BEEF, 1'b0);
      check_eq("sh_mem", dmem[8], 32'hBEEF3344);
      // word store then load back
      do_req(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 1'b0);
      do_req(1'b0, 3'b010, 32'h40, 32'h0, 1'b0);
      check_eq("lw_const", resp_data, 32'hCAFEF00D);
      // rejected requests
      do_req(1'b0, 3'b010, 32'h42, 32'h0, 1'b0);
      do_req(1'b1, 3'b001, 32'h21, 32'h1234, 1'b0);
      do_req(1'b1, 3'b100, 32'h10, 32'h77, 1'b0);
      do_req(1'b0, 3'b010, 32'h400, 32'h0, 1'b0);
      check_eq("err_data", resp_data, 32'h0);
      idle_check(3);

      // request held high while busy: exactly one operation each
      do_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b1);
      idle_check(3);
      do_req(1'b1, 3'b000, 32'h13, 32'hA5, 1'b1);
      idle_check(3);

      // reset during the read phase of a byte store
      req_store = 1'b1; req_op = 3'b000; req_addr = 32'h30; req_wdata = 32'h55;
      req_valid = 1'b1;
      @(posedge clock);
      #1 req_valid = 1'b0;
      @(negedge clock);
      check_eq("rst_leitura", MemRead, 1);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("midrst");
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      last_data = 32'h0;
      check_eq("rst_mem", dmem[12], ref_mem[12]);
      idle_check(2);

      // random traffic, back to back
      repeat (80) begin
         if ($urandom_range(0, 9) == 0) a = $urandom;
         else a = 32'($urandom_range(0, MEM_WORDS * 4 - 1));
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                1'($urandom_range(0, 1)));
      end
      idle_check(2);

      for (int i = 0; i < MEM_WORDS; i++)
         check_eq($sformatf("mem[%0d]", i), dmem[i], ref_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
